ascii_ram_write_scheduler: RTL and testbench
============================================

ASCII_RAM_WRITE_SCHEDULER -- requirements
Module: ascii_ram_write_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the ASCII text RAM address width.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the write-FIFO entry count (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port cpu_we, input, 1 bit: the CPU write request strobe, one write per cycle.
REQ-006 SHALL have port cpu_waddr, input, ADDR_W bits: the text RAM cell address of the CPU write.
REQ-007 SHALL have port cpu_wdata, input, 8 bits: the ASCII code to write.
REQ-008 SHALL have port cpu_ready, output, 1 bit: FIFO not full; a write is accepted only when cpu_we and cpu_ready are both high.
REQ-009 SHALL have port blank, input, 1 bit: early blanking flag from VGA timing; it deasserts at least 1 clk before the first active pixel.
REQ-010 SHALL have port vga_raddr, input, ADDR_W bits: the VGA character-fetch address.
REQ-011 SHALL have port ram_addr, output, ADDR_W bits: the text RAM address.
REQ-012 SHALL have port ram_wdata, output, 8 bits: the text RAM write data.
REQ-013 SHALL have port ram_we, output, 1 bit: the text RAM write enable.
REQ-014 SHALL have port fifo_count, output, log2(DEPTH)+1 bits: the number of entries held.
REQ-015 SHALL have port busy, output, 1 bit: high while the FSM is in DRAIN.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.

Function
REQ-017 SHALL buffer accepted CPU writes in a FIFO of DEPTH {addr, data} entries with wrapping read and write pointers.
REQ-018 SHALL set cpu_ready = (fifo_count != DEPTH) combinationally from registered state.
REQ-019 SHALL, when cpu_we is high and the FIFO is full, drop the write, leave the FIFO unchanged, and set overflow to 1 on the next edge.
REQ-020 SHALL implement a 2-state FSM: IDLE and DRAIN.
REQ-021 SHALL transition IDLE->DRAIN on an edge where blank=1 and fifo_count!=0.
REQ-022 SHALL transition DRAIN->IDLE on an edge where blank=0, or where the FIFO empties after a pop with no concurrent push.
REQ-023 SHALL, on each edge in DRAIN with blank=1 and fifo_count!=0, pop the head entry, register its addr/data to ram_addr/ram_wdata, and set ram_we=1 for exactly that next cycle.
REQ-024 SHALL, on every other edge, register ram_we=0 and ram_addr=vga_raddr, and hold ram_wdata at its previous value.
REQ-025 SHALL drain at most one write per clk (no bursts wider than one entry per cycle).
REQ-026 SHALL have a latency of 2 edges from acceptance to ram_we assertion when blank is already high and the FIFO was empty (edge 1: push and enter DRAIN; edge 2: pop).
REQ-027 SHALL, on a simultaneous push and pop, leave fifo_count unchanged and allow a push into the slot freed in the same cycle only if cpu_ready was high at that edge (no full-bypass).
REQ-028 SHALL drain writes in strict acceptance order; a later write to the same address overwrites an earlier one in RAM.
REQ-029 SHALL never assert ram_we in a cycle following an edge where blank was sampled 0.
REQ-030 SHALL keep fifo_count within 0..DEPTH, with pointer arithmetic modulo DEPTH.

Reset
REQ-031 SHALL, on rst=1 (asynchronous), immediately set FSM=IDLE, pointers=0, fifo_count=0, ram_we=0, ram_addr=0, ram_wdata=0, overflow=0, and busy=0.
REQ-032 SHALL, on rst asserted mid-DRAIN, discard pending entries and perform no further RAM writes until new writes are accepted after rst release.
REQ-033 SHALL make overflow clearable only by rst.

Verification
REQ-034 SHALL verify: blank=0, write (0x005,0x41) then (0x006,0x42) -> fifo_count=2, ram_we stays 0, and ram_addr tracks vga_raddr.
REQ-035 SHALL verify: then blank=1 -> ram_we=1 with 0x005/0x41, then 0x006/0x42 on consecutive cycles, then busy=0 and fifo_count=0.
REQ-036 SHALL verify: 9 writes with DEPTH=8 and blank=0 -> the 9th is dropped, overflow=1, cpu_ready=0, and only 8 entries drain later.
REQ-037 SHALL verify: blank falls after 3 of 5 drained -> exactly 3 ram_we pulses, FSM=IDLE, and the remaining 2 drain in the next blank.
REQ-038 SHALL verify: push and pop in the same cycle at fifo_count=4 -> fifo_count stays 4 and order is preserved.
REQ-039 SHALL verify: rst pulse during DRAIN with fifo_count=3 -> all outputs reach reset values immediately, with no further ram_we.

Source files
------------

// File: rtl/ascii_ram_write_scheduler.sv
// Buffers CPU text-RAM writes in a small FIFO and drains them one per clock during
// VGA blanking, so character fetches never collide with CPU writes.
module ascii_ram_write_scheduler #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      cpu_waddr,
    input  logic [7:0]             cpu_wdata,
    output logic                   cpu_ready,
    input  logic                   blank,
    input  logic [ADDR_W-1:0]      vga_raddr,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [7:0]             ram_wdata,
    output logic                   ram_we,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [0:0] {
        StIdle,
        StDrain
    } state_e;

    state_e            r_state;
    state_e            w_state_d;

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [7:0]        r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_d;

    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [7:0]        r_ram_wdata;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A push is only granted against the registered fill level, so a full FIFO
    // never accepts into the slot being freed by a concurrent pop.
    assign w_push = cpu_we && !w_full;
    assign w_drop = cpu_we && w_full;
    assign w_pop  = (r_state == StDrain) && blank && !w_empty;

    always_comb begin
        w_count_d = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CNT_W'(1);
            2'b01:   w_count_d = r_count - CNT_W'(1);
            default: w_count_d = r_count;
        endcase
    end

    // Entering DRAIN counts a same-cycle push so a lone write lands two edges later.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (blank && (!w_empty || w_push)) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (!blank) begin
                    w_state_d = StIdle;
                end else if (w_pop && !w_push && (r_count == CNT_W'(1))) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= cpu_waddr;
            r_mem_data[r_wptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= w_count_d;
        end
    end

    // Outside a drain slot the RAM port follows the VGA fetch address; write data
    // is held so the data bus stays quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_pop) begin
            r_ram_we    <= 1'b1;
            r_ram_addr  <= r_mem_addr[r_rptr];
            r_ram_wdata <= r_mem_data[r_rptr];
        end else begin
            r_ram_we    <= 1'b0;
            r_ram_addr  <= vga_raddr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign cpu_ready  = !w_full;
    assign fifo_count = r_count;
    assign busy       = (r_state == StDrain);
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ascii_ram_write_scheduler.sv
// Directed bench: a vector table for the basic buffer/drain flow, then hand-written
// sequences for overflow, blank interruption, push/pop overlap and reset mid-drain.
module tb_ascii_ram_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic [11:0] cpu_waddr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic        blank;
    logic [11:0] vga_raddr;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [3:0]  fifo_count;
    logic        busy;
    logic        overflow;

    ascii_ram_write_scheduler #(
        .ADDR_W(12),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_we    (cpu_we),
        .cpu_waddr (cpu_waddr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .blank     (blank),
        .vga_raddr (vga_raddr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .fifo_count(fifo_count),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] waddr;
        logic [7:0]  wdata;
        logic        blank;
        logic [11:0] vraddr;
        logic        e_we;
        logic [11:0] e_addr;
        logic [7:0]  e_wdata;
        logic [3:0]  e_cnt;
        logic        e_busy;
        logic        e_ready;
        logic        e_ovf;
    } vec_t;

    vec_t        vecs [10];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pulses = 0;
    int          base;
    bit          sb_en = 1'b0;
    logic [19:0] exp_q [$];
    logic [19:0] e_front;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d, input bit accept);
        cpu_we    = 1'b1;
        cpu_waddr = a;
        cpu_wdata = d;
        if (accept) exp_q.push_back({a, d});
        tick();
        cpu_we = 1'b0;
    endtask

    // Every RAM write seen while the scoreboard is armed must match the next accepted write.
    always @(negedge clk) begin
        if (sb_en && !rst && ram_we === 1'b1) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         ram_addr, ram_wdata);
            end else begin
                e_front = exp_q.pop_front();
                chk("sb_order", {12'h0, ram_addr, ram_wdata}, {12'h0, e_front});
            end
        end
    end

    initial begin
        // we, waddr, wdata, blank, vraddr | e_we, e_addr, e_wdata, e_cnt, e_busy, e_ready, e_ovf
        vecs[0] = '{1'b1, 12'h005, 8'h41, 1'b0, 12'h100, 1'b0, 12'h100, 8'h00, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 12'h006, 8'h42, 1'b0, 12'h101, 1'b0, 12'h101, 8'h00, 4'd2, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h102, 1'b0, 12'h102, 8'h00, 4'd2, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h103, 1'b0, 12'h103, 8'h00, 4'd2, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h104, 1'b1, 12'h005, 8'h41, 4'd1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h105, 1'b1, 12'h006, 8'h42, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h106, 1'b0, 12'h106, 8'h42, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 12'h0AA, 8'h55, 1'b1, 12'h107, 1'b0, 12'h107, 8'h42, 4'd1, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h108, 1'b1, 12'h0AA, 8'h55, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h109, 1'b0, 12'h109, 8'h55, 4'd0, 1'b0, 1'b1, 1'b0};

        rst       = 1'b1;
        cpu_we    = 1'b0;
        cpu_waddr = '0;
        cpu_wdata = '0;
        blank     = 1'b0;
        vga_raddr = '0;
        repeat (2) tick();
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Buffer two writes outside blanking, then drain them; then a single-write latency case.
        for (int i = 0; i < 10; i++) begin
            cpu_we    = vecs[i].we;
            cpu_waddr = vecs[i].waddr;
            cpu_wdata = vecs[i].wdata;
            blank     = vecs[i].blank;
            vga_raddr = vecs[i].vraddr;
            tick();
            chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].e_wdata));
            chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d_ready", i), 32'(cpu_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
        end
        cpu_we = 1'b0;

        // Blank drops after three of five entries have drained.
        sb_en = 1'b1;
        blank = 1'b0;
        for (int i = 0; i < 5; i++) wr(12'h010 + 12'(i), 8'h60 + 8'(i), 1'b1);
        chk("int_count5", 32'(fifo_count), 32'd5);
        blank = 1'b1;
        repeat (4) tick();
        blank = 1'b0;
        tick();
        chk("int_pulses3", 32'(n_pulses), 32'd3);
        chk("int_busy0", 32'(busy), 32'd0);
        chk("int_ram_we0", 32'(ram_we), 32'd0);
        chk("int_count2", 32'(fifo_count), 32'd2);
        blank = 1'b1;
        repeat (4) tick();
        chk("int_pulses5", 32'(n_pulses), 32'd5);
        chk("int_count0", 32'(fifo_count), 32'd0);
        chk("int_busy_end", 32'(busy), 32'd0);
        chk("int_q_empty", 32'(exp_q.size()), 32'd0);

        // Push and pop on the same edge with four entries held.
        blank = 1'b0;
        for (int i = 0; i < 4; i++) wr(12'h020 + 12'(i), 8'h70 + 8'(i), 1'b1);
        blank = 1'b1;
        tick();
        chk("pp_busy", 32'(busy), 32'd1);
        wr(12'h024, 8'h74, 1'b1);
        chk("pp_count4", 32'(fifo_count), 32'd4);
        chk("pp_ram_we", 32'(ram_we), 32'd1);
        chk("pp_ram_addr", 32'(ram_addr), 32'h020);
        repeat (5) tick();
        chk("pp_count0", 32'(fifo_count), 32'd0);
        chk("pp_busy0", 32'(busy), 32'd0);
        chk("pp_pulses", 32'(n_pulses), 32'd10);
        chk("pp_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset pulse mid-drain with three entries still queued.
        sb_en = 1'b0;
        blank = 1'b0;
        for (int i = 0; i < 4; i++) wr(12'h030 + 12'(i), 8'h90 + 8'(i), 1'b0);
        blank = 1'b1;
        repeat (2) tick();
        chk("mr_busy", 32'(busy), 32'd1);
        chk("mr_count3", 32'(fifo_count), 32'd3);
        chk("mr_ram_we", 32'(ram_we), 32'd1);
        chk("mr_ram_addr", 32'(ram_addr), 32'h030);
        rst = 1'b1;
        #1;
        chk("mr_ram_we0", 32'(ram_we), 32'd0);
        chk("mr_ram_addr0", 32'(ram_addr), 32'd0);
        chk("mr_ram_wdata0", 32'(ram_wdata), 32'd0);
        chk("mr_count0", 32'(fifo_count), 32'd0);
        chk("mr_busy0", 32'(busy), 32'd0);
        chk("mr_ovf0", 32'(overflow), 32'd0);
        repeat (2) tick();
        rst   = 1'b0;
        base  = n_pulses;
        sb_en = 1'b1;
        repeat (5) tick();
        chk("mr_no_writes", 32'(n_pulses), 32'(base));
        chk("mr_idle", 32'(busy), 32'd0);
        chk("mr_count_after", 32'(fifo_count), 32'd0);

        // Nine writes into an eight-entry FIFO; the ninth is dropped.
        blank = 1'b0;
        for (int i = 0; i < 8; i++) wr(12'h040 + 12'(i), 8'h80 + 8'(i), 1'b1);
        chk("of_count8", 32'(fifo_count), 32'd8);
        chk("of_ready0", 32'(cpu_ready), 32'd0);
        chk("of_ovf_pre", 32'(overflow), 32'd0);
        wr(12'h048, 8'h88, 1'b0);
        chk("of_ovf1", 32'(overflow), 32'd1);
        chk("of_count_hold", 32'(fifo_count), 32'd8);
        chk("of_ready_hold", 32'(cpu_ready), 32'd0);
        base  = n_pulses;
        blank = 1'b1;
        repeat (11) tick();
        chk("of_pulses8", 32'(n_pulses - base), 32'd8);
        chk("of_count0", 32'(fifo_count), 32'd0);
        chk("of_ready1", 32'(cpu_ready), 32'd1);
        chk("of_ovf_sticky", 32'(overflow), 32'd1);
        chk("of_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
